// File: rtl/fir_pkg.sv
// fir_pkg: shared helpers for the fir_stream filter.
//   calc_acc_w  - accumulator width with headroom for every tap sum
//   calc_addr_w - coefficient address width for a given tap count
//   round_sat   - round half toward +inf, arithmetic shift, clamp to width
package fir_pkg;

   // Width of the intermediate used by round_sat; covers any sane ACC_W.
   localparam int SAT_W = 64;

   function automatic int calc_acc_w(input int d_w, input int c_w, input int c_num);
      return d_w + c_w + $clog2(c_num);
   endfunction

   function automatic int calc_addr_w(input int c_num);
      return (c_num > 32'sd1) ? $clog2(c_num) : 32'sd1;
   endfunction

   function automatic logic signed [SAT_W-1:0] round_sat(
      input logic signed [SAT_W-1:0] val,
      input int                      shift,
      input int                      width
   );
      logic signed [SAT_W-1:0] tmp_s;
      logic signed [SAT_W-1:0] max_s;
      logic signed [SAT_W-1:0] min_s;
      tmp_s = val;
      if (shift > 32'sd0) begin
         tmp_s = tmp_s + (64'sd1 <<< (shift - 32'sd1));
      end else begin
         tmp_s = val;
      end
      tmp_s = tmp_s >>> shift;
      max_s = (64'sd1 <<< (width - 32'sd1)) - 64'sd1;
      min_s = -(64'sd1 <<< (width - 32'sd1));
      if (tmp_s > max_s) begin
         return max_s;
      end else if (tmp_s < min_s) begin
         return min_s;
      end else begin
         return tmp_s;
      end
   endfunction

endpackage

// File: rtl/fir_tap.sv
// fir_tap: one transposed-form FIR stage.
//   clock, reset  - clock and asynchronous active-low reset
//   clear         - synchronous flush of the partial sum
//   en            - advance on an accepted sample
//   coeff, sample - multiplicands (signed)
//   psum_up       - partial sum from the next-higher tap
//   psum          - registered partial sum handed to the next-lower tap
module fir_tap #(
   parameter int D_W   = 12,
   parameter int C_W   = 12,
   parameter int ACC_W = 29
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    en,
   input  logic signed [C_W-1:0]   coeff,
   input  logic signed [D_W-1:0]   sample,
   input  logic signed [ACC_W-1:0] psum_up,
   output logic signed [ACC_W-1:0] psum
);

   logic signed [ACC_W-1:0] prod_s;
   logic signed [ACC_W-1:0] psum_r;

   // Sign-extend both operands first so the product is exact at ACC_W.
   assign prod_s = ACC_W'(coeff) * ACC_W'(sample);
   assign psum   = psum_r;

   // Partial-sum register: clear wins, otherwise update only on accept.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         psum_r <= '0;
      end else if (clear) begin
         psum_r <= '0;
      end else if (en) begin
         psum_r <= psum_up + prod_s;
      end
   end

endmodule

// File: rtl/fir_stream.sv
// fir_stream: streaming transposed-form FIR with valid/ready handshake,
// double-buffered runtime coefficients and round/shift/saturate output.
//   clock, reset              - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data - sample input handshake
//   out_valid/out_ready/out_data - filtered output handshake
//   coeff_wr_en/addr/data     - write one shadow coefficient
//   coeff_commit              - copy the whole shadow bank to the active bank
//   clear                     - synchronous flush of partial sums and output
module fir_stream
   import fir_pkg::*;
#(
   parameter int D_W       = 12,
   parameter int C_W       = 12,
   parameter int C_NUM     = 31,
   parameter int OUT_W     = 12,
   parameter int OUT_SHIFT = 11
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [D_W-1:0]             in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [OUT_W-1:0]           out_data,
   input  logic                              coeff_wr_en,
   input  logic [calc_addr_w(C_NUM)-1:0]     coeff_wr_addr,
   input  logic signed [C_W-1:0]             coeff_wr_data,
   input  logic                              coeff_commit,
   input  logic                              clear
);

   localparam int ACC_W = calc_acc_w(D_W, C_W, C_NUM);

   logic signed [C_W-1:0]   shadow_r [C_NUM];
   logic signed [C_W-1:0]   active_r [C_NUM];
   logic signed [ACC_W-1:0] acc_s    [1:C_NUM-1];
   logic signed [ACC_W-1:0] prod0_s;
   logic signed [ACC_W-1:0] res_s;
   logic signed [OUT_W-1:0] out_data_r;
   logic                    out_valid_r;
   logic                    accept_s;
   logic                    wr_hit_s;

   // The pipeline only moves when the output slot is free or being drained;
   // clear blocks acceptance so a flushed cycle never swallows a sample.
   assign in_ready  = (!out_valid_r || out_ready) && !clear;
   assign accept_s  = in_valid && in_ready;
   assign wr_hit_s  = coeff_wr_en && (32'(coeff_wr_addr) < C_NUM);
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;

   // Tap c[0] is folded into the output adder instead of a register stage.
   assign prod0_s = ACC_W'(active_r[0]) * ACC_W'(in_data);
   assign res_s   = acc_s[1] + prod0_s;

   for (genvar k = 1; k < C_NUM; k++) begin : g_tap
      logic signed [ACC_W-1:0] up_s;
      if (k == C_NUM - 1) begin : g_last
         assign up_s = '0;
      end else begin : g_mid
         assign up_s = acc_s[k+1];
      end
      fir_tap #(
         .D_W   (D_W),
         .C_W   (C_W),
         .ACC_W (ACC_W)
      ) u_tap (
         .clock   (clock),
         .reset   (reset),
         .clear   (clear),
         .en      (accept_s),
         .coeff   (active_r[k]),
         .sample  (in_data),
         .psum_up (up_s),
         .psum    (acc_s[k])
      );
   end

   // Coefficient banks: commit copies the pre-edge shadow, so a same-cycle
   // write lands only in the shadow; clear deliberately leaves both alone.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < C_NUM; i++) begin
            shadow_r[i] <= '0;
            active_r[i] <= '0;
         end
      end else begin
         if (coeff_commit) begin
            active_r <= shadow_r;
         end
         if (wr_hit_s) begin
            shadow_r[coeff_wr_addr] <= coeff_wr_data;
         end
      end
   end

   // Output register: loads on accept, drops valid once drained, holds
   // under backpressure.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
      end else if (clear) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
      end else if (accept_s) begin
         out_data_r  <= OUT_W'(round_sat(SAT_W'(res_s), OUT_SHIFT, OUT_W));
         out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream: randomized and directed bench for fir_stream against a
// history-based convolution model y[n] = sum c_n-k[k] * x[n-k].
module tb_fir_stream;

   localparam int D_W       = 12;
   localparam int C_W       = 12;
   localparam int C_NUM     = 31;
   localparam int OUT_W     = 12;
   localparam int OUT_SHIFT = 1;
   localparam int AW        = 5;
   localparam int MAXS      = 2048;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [D_W-1:0]   in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_data;
   logic             coeff_wr_en = 1'b0;
   logic [AW-1:0]    coeff_wr_addr = '0;
   logic [C_W-1:0]   coeff_wr_data = '0;
   logic             coeff_commit = 1'b0;
   logic             clear = 1'b0;

   always #5 clock = ~clock;

   fir_stream #(
      .D_W(D_W), .C_W(C_W), .C_NUM(C_NUM), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
      .coeff_wr_data(coeff_wr_data), .coeff_commit(coeff_commit), .clear(clear)
   );

   int     vec_cnt = 0;
   int     err_cnt = 0;
   int     m_shadow [C_NUM];
   int     m_active [C_NUM];
   int     hx [MAXS];
   int     hc [MAXS][C_NUM];
   int     m_n;
   bit     m_ov;
   longint m_od;

   task automatic check_eq(input string tag, input longint act, input longint exp);
      vec_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic longint ref_out(input longint r);
      longint v;
      longint hi;
      longint lo;
      v  = r;
      if (OUT_SHIFT > 0) v = v + (longint'(1) <<< (OUT_SHIFT - 1));
      v  = v >>> OUT_SHIFT;
      hi = (longint'(1) <<< (OUT_W - 1)) - 1;
      lo = -(longint'(1) <<< (OUT_W - 1));
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   task automatic model_reset(input bit banks);
      m_n  = 0;
      m_ov = 1'b0;
      m_od = 0;
      if (banks) begin
         for (int k = 0; k < C_NUM; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
         end
      end
   endtask

   task automatic wr(input int addr, input int data);
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = AW'(addr);
      coeff_wr_data = C_W'(data);
   endtask

   // One clock: drive, check in_ready, advance model at the edge, check outputs.
   task automatic step(input bit v, input int d, input bit ordy, input bit clr);
      bit     exp_rdy;
      longint r;
      in_valid  = v;
      in_data   = D_W'(d);
      out_ready = ordy;
      clear     = clr;
      #1;
      exp_rdy = (!m_ov || ordy) && !clr;
      check_eq("in_ready", longint'(in_ready), longint'(exp_rdy));
      @(posedge clock);
      if (clr) begin
         model_reset(1'b0);
      end else if (v && exp_rdy) begin
         if (m_n >= MAXS) begin
            $display("FAIL model_depth: got %0d, expected below %0d", m_n, MAXS);
            $fatal(1, "history overflow");
         end
         hx[m_n] = d;
         for (int k = 0; k < C_NUM; k++) hc[m_n][k] = m_active[k];
         r = 0;
         for (int k = 0; k < C_NUM && k <= m_n; k++)
            r += longint'(hc[m_n-k][k]) * longint'(hx[m_n-k]);
         m_n++;
         m_od = ref_out(r);
         m_ov = 1'b1;
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
      if (coeff_commit) m_active = m_shadow;
      if (coeff_wr_en && int'(coeff_wr_addr) < C_NUM)
         m_shadow[coeff_wr_addr] = int'($signed(coeff_wr_data));
      #1;
      check_eq("out_valid", longint'(out_valid), longint'(m_ov));
      check_eq("out_data", $signed(out_data), m_od);
      coeff_wr_en  = 1'b0;
      coeff_commit = 1'b0;
      in_valid     = 1'b0;
   endtask

   initial begin
      longint hold;
      int     bp;
      bit     ordy;
      model_reset(1'b1);
      #2;
      check_eq("rst_valid", longint'(out_valid), 0);
      check_eq("rst_data", $signed(out_data), 0);
      #10 reset = 1'b1;

      // Impulse response with c[k] = k+1; x=2 cancels the 1-bit rounding shift.
      for (int k = 0; k < C_NUM; k++) begin
         wr(k, k + 1);
         step(1'b0, 0, 1'b1, 1'b0);
      end
      coeff_commit = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0);
      for (int n = 0; n <= C_NUM; n++) begin
         step(1'b1, (n == 0) ? 2 : 0, 1'b1, 1'b0);
         check_eq("impulse", $signed(out_data), (n < C_NUM) ? n + 1 : 0);
      end

      // Coefficient swap: shadow reloaded mid-stream, commit on an accepted impulse.
      for (int n = 0; n <= C_NUM; n++) begin
         if (n < C_NUM) wr(n, C_NUM - n);
         step(1'b1, (n == 0) ? 2 : 0, 1'b1, 1'b0);
      end
      wr(0, 77);
      coeff_commit = 1'b1;
      step(1'b1, 2, 1'b1, 1'b0);
      check_eq("swap_old", $signed(out_data), 1);
      for (int n = 1; n <= C_NUM; n++) begin
         step(1'b1, 0, 1'b1, 1'b0);
         check_eq("swap_old_tail", $signed(out_data), (n < C_NUM) ? n + 1 : 0);
      end
      for (int n = 0; n <= C_NUM; n++) begin
         step(1'b1, (n == 0) ? 2 : 0, 1'b1, 1'b0);
         check_eq("swap_new", $signed(out_data), (n < C_NUM) ? C_NUM - n : 0);
      end

      // Clear mid-stream, then a clean impulse with retained coefficients.
      step(1'b1, 2, 1'b1, 1'b0);
      step(1'b1, 2, 1'b1, 1'b0);
      step(1'b1, 5, 1'b1, 1'b1);
      check_eq("clear_valid", longint'(out_valid), 0);
      for (int n = 0; n <= C_NUM; n++) begin
         step(1'b1, (n == 0) ? 2 : 0, 1'b1, 1'b0);
         check_eq("clear_impulse", $signed(out_data), (n < C_NUM) ? C_NUM - n : 0);
      end

      // Saturation with all coefficients at full scale.
      for (int k = 0; k < C_NUM; k++) begin
         wr(k, 2047);
         step(1'b0, 0, 1'b1, 1'b0);
      end
      coeff_commit = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0);
      for (int n = 0; n < 40; n++) step(1'b1, 2047, 1'b1, 1'b0);
      check_eq("sat_pos", $signed(out_data), 2047);
      for (int n = 0; n < 40; n++) step(1'b1, -2048, 1'b1, 1'b0);
      check_eq("sat_neg", $signed(out_data), -2048);

      // Rounding with c[0]=1 only.
      for (int k = 0; k < C_NUM; k++) begin
         wr(k, (k == 0) ? 1 : 0);
         step(1'b0, 0, 1'b1, 1'b0);
      end
      coeff_commit = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b1);
      step(1'b1, 3, 1'b1, 1'b0);
      check_eq("round_p3", $signed(out_data), 2);
      step(1'b1, -3, 1'b1, 1'b0);
      check_eq("round_m3", $signed(out_data), -1);
      step(1'b1, 2, 1'b1, 1'b0);
      check_eq("round_p2", $signed(out_data), 1);

      // Backpressure: five stalled cycles with a sample offered each time.
      for (int k = 0; k < C_NUM; k++) begin
         wr(k, int'($urandom_range(0, 15)) - 8);
         step(1'b0, 0, 1'b1, 1'b0);
      end
      coeff_commit = 1'b1;
      step(1'b0, 0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) step(1'b1, int'($urandom_range(0, 127)) - 64, 1'b1, 1'b0);
      hold = $signed(out_data);
      for (int n = 0; n < 5; n++) begin
         step(1'b1, int'($urandom_range(0, 127)) - 64, 1'b0, 1'b0);
         check_eq("bp_hold", $signed(out_data), hold);
      end
      for (int n = 0; n < 8; n++) step(1'b1, int'($urandom_range(0, 127)) - 64, 1'b1, 1'b0);

      // Randomized traffic: gaps, stalls, writes, commits and rare clears.
      bp = 0;
      for (int i = 0; i < 600; i++) begin
         if (bp > 0) begin
            bp--;
            ordy = 1'b0;
         end else begin
            ordy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bp = 5;
         end
         if ($urandom_range(0, 7) == 0) wr(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)) - 8);
         if ($urandom_range(0, 39) == 0) coeff_commit = 1'b1;
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)) - 64, ordy,
              $urandom_range(0, 99) == 0);
      end

      // Asynchronous reset mid-cycle, then a post-reset sample with zero coefficients.
      step(1'b1, 5, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_eq("async_rst_valid", longint'(out_valid), 0);
      check_eq("async_rst_data", $signed(out_data), 0);
      model_reset(1'b1);
      #3 reset = 1'b1;
      step(1'b1, 100, 1'b1, 1'b0);
      check_eq("post_rst_data", $signed(out_data), 0);
      check_eq("post_rst_valid", longint'(out_valid), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
